// File: rtl/triangle_ram_loader.sv
// Writer side of the DDFS waveform RAM: packs a host byte stream into big-endian
// 16-bit words and writes them from a start address, wrapping. TRI_AUTOGEN_EN adds a
// built-in triangle table generator (GEN state).
module triangle_ram_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Start_Addr,
   input  logic [ADDR_W:0]   Word_Count,
   input  logic              Autogen,
   input  logic [7:0]        Byte_in,
   input  logic              Byte_Valid,
   output logic              Byte_Ready,
   output logic [ADDR_W-1:0] Triangle_Addr,
   output logic [DATA_W-1:0] Triangle_Data,
   output logic              TriRAM_WE,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Checksum
);

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      WRITE,
      DONE
`ifdef TRI_AUTOGEN_EN
      , GEN
`endif
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [ADDR_W:0]     remaining;
   logic [7:0]          hi_byte;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                hs;
   logic [ADDR_W:0]     count_load;

   assign hs = Byte_Valid && Byte_Ready;
   // Word_Count of zero means a full-table load.
   assign count_load = (Word_Count == '0) ? (ADDR_W+1)'(1 << ADDR_W) : Word_Count;

`ifdef TRI_AUTOGEN_EN
   // Symmetric triangle: rising half, then the mirrored falling half.
   function automatic logic [DATA_W-1:0] tri_val(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-2:0] ramp;
      ramp = a[ADDR_W-1] ? ~a[ADDR_W-2:0] : a[ADDR_W-2:0];
      return {ramp, {(DATA_W-ADDR_W+1){1'b0}}};
   endfunction

   logic [DATA_W-1:0] gen_data;
   assign gen_data = tri_val(addr_cnt);

   // During GEN the counter drives the port directly so data leads WE by no cycles.
   assign Triangle_Addr = (state == GEN) ? addr_cnt : addr_q;
   assign Triangle_Data = (state == GEN) ? gen_data : data_q;
`else
   logic unused_autogen;
   assign unused_autogen = Autogen;
   assign Triangle_Addr  = addr_q;
   assign Triangle_Data  = data_q;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      Byte_Ready = 1'b0;
      TriRAM_WE  = 1'b0;
      Busy       = 1'b1;
      Done       = 1'b0;
      case (state)
         IDLE: begin
            Busy = 1'b0;
            if (Start) begin
`ifdef TRI_AUTOGEN_EN
               state_nxt = Autogen ? GEN : HI;
`else
               state_nxt = HI;
`endif
            end
         end
         HI: begin
            Byte_Ready = 1'b1;
            if (hs) state_nxt = LO;
         end
         LO: begin
            Byte_Ready = 1'b1;
            if (hs) state_nxt = WRITE;
         end
         WRITE: begin
            TriRAM_WE = 1'b1;
            state_nxt = (remaining == (ADDR_W+1)'(1)) ? DONE : HI;
         end
         DONE: begin
            Done      = 1'b1;
            state_nxt = IDLE;
         end
`ifdef TRI_AUTOGEN_EN
         GEN: begin
            TriRAM_WE = 1'b1;
            if (addr_cnt == '1) state_nxt = DONE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         addr_cnt  <= '0;
         remaining <= '0;
         hi_byte   <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         Checksum  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  Checksum  <= '0;
                  addr_cnt  <= Start_Addr;
                  remaining <= count_load;
`ifdef TRI_AUTOGEN_EN
                  if (Autogen) addr_cnt <= '0;
`endif
               end
            end
            HI: if (hs) hi_byte <= Byte_in;
            LO: begin
               if (hs) begin
                  addr_q <= addr_cnt;
                  data_q <= {hi_byte, Byte_in};
               end
            end
            WRITE: begin
               Checksum  <= Checksum + data_q;
               addr_cnt  <= addr_cnt + 1'b1;
               remaining <= remaining - 1'b1;
            end
`ifdef TRI_AUTOGEN_EN
            GEN: begin
               Checksum <= Checksum + gen_data;
               addr_q   <= addr_cnt;
               data_q   <= gen_data;
               addr_cnt <= addr_cnt + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_triangle_ram_loader.sv
// Directed bench for triangle_ram_loader: byte loads, address wrap, full-table load,
// mid-load reset and (when TRI_AUTOGEN_EN is defined) the triangle generator.
module tb_triangle_ram_loader;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [9:0]  Start_Addr = '0;
   logic [10:0] Word_Count = '0;
   logic        Autogen = 1'b0;
   logic [7:0]  Byte_in = '0;
   logic        Byte_Valid = 1'b0;
   logic        Byte_Ready;
   logic [9:0]  Triangle_Addr;
   logic [15:0] Triangle_Data;
   logic        TriRAM_WE;
   logic        Busy;
   logic        Done;
   logic [15:0] Checksum;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [9:0]  wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   int          dc[$];

   triangle_ram_loader dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Start_Addr(Start_Addr),
      .Word_Count(Word_Count), .Autogen(Autogen), .Byte_in(Byte_in),
      .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready), .Triangle_Addr(Triangle_Addr),
      .Triangle_Data(Triangle_Data), .TriRAM_WE(TriRAM_WE), .Busy(Busy), .Done(Done),
      .Checksum(Checksum)
   );

   always #5 Clock = ~Clock;

   // Write/Done monitor, sampled mid-cycle.
   always @(negedge Clock) begin
      if (TriRAM_WE) begin
         wa.push_back(Triangle_Addr);
         wd.push_back(Triangle_Data);
         wc.push_back(cyc);
      end
      if (Done) dc.push_back(cyc);
   end

   task automatic step();
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete(); dc.delete();
   endtask

   task automatic start_load(input logic [9:0] sa, input logic [10:0] wcnt, input logic ag);
      Start_Addr = sa; Word_Count = wcnt; Autogen = ag; Start = 1'b1;
      step();
      Start = 1'b0; Autogen = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      Byte_in = b; Byte_Valid = 1'b1;
      while (!Byte_Ready && n < 20) begin step(); n++; end
      if (!Byte_Ready) chk("ready_timeout", 32'(Byte_Ready), 32'd1);
      step();
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!Done && n < limit) begin step(); n++; end
      if (!Done) chk("done_timeout", 32'(Done), 32'd1);
   endtask

   initial begin
      // Reset and idle behaviour
      step(); step();
      Reset = 1'b0;
      step();
      chk("rst_ready", 32'(Byte_Ready), 32'd0);
      chk("rst_we",    32'(TriRAM_WE),  32'd0);
      chk("rst_busy",  32'(Busy),       32'd0);
      chk("rst_done",  32'(Done),       32'd0);
      chk("rst_addr",  32'(Triangle_Addr), 32'd0);
      chk("rst_data",  32'(Triangle_Data), 32'd0);
      chk("rst_csum",  32'(Checksum),   32'd0);
      Byte_in = 8'h55; Byte_Valid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("idle_ready", 32'(Byte_Ready), 32'd0);
      chk("idle_nowr",  32'(wa.size()),  32'd0);
      Byte_Valid = 1'b0;

      // Two-word load at 0x005
      clear_log();
      start_load(10'h005, 11'd2, 1'b0);
      chk("t2_busy",  32'(Busy),       32'd1);
      chk("t2_ready", 32'(Byte_Ready), 32'd1);
      send_word(16'h1234);
      send_word(16'hABCD);
      wait_done(10);
      chk("t2_csum_done", 32'(Checksum), 32'hBE01);
      Byte_Valid = 1'b0;
      step();
      chk("t2_busy_end", 32'(Busy), 32'd0);
      chk("t2_done_end", 32'(Done), 32'd0);
      chk("t2_nwr", 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         chk("t2_a0", 32'(wa[0]), 32'h005);
         chk("t2_d0", 32'(wd[0]), 32'h1234);
         chk("t2_a1", 32'(wa[1]), 32'h006);
         chk("t2_d1", 32'(wd[1]), 32'hABCD);
         chk("t2_gap", 32'(wc[1] - wc[0]), 32'd3);
         chk("t2_ndone", 32'(dc.size()), 32'd1);
         if (dc.size() == 1) chk("t2_done_cyc", 32'(dc[0] - wc[1]), 32'd1);
      end
      chk("t2_addr_hold", 32'(Triangle_Addr), 32'h006);
      chk("t2_data_hold", 32'(Triangle_Data), 32'hABCD);

      // Wrap at 0x3FF; a Start pulse while busy must be ignored
      clear_log();
`ifdef TRI_AUTOGEN_EN
      start_load(10'h3FF, 11'd3, 1'b0);
`else
      start_load(10'h3FF, 11'd3, 1'b1);
`endif
      send_word(16'h0001);
      Start_Addr = 10'h200; Word_Count = 11'd1; Start = 1'b1;
      send_word(16'h0002);
      Start = 1'b0;
      send_word(16'h0003);
      wait_done(10);
      chk("t3_csum", 32'(Checksum), 32'h0006);
      Byte_Valid = 1'b0;
      step();
      chk("t3_nwr", 32'(wa.size()), 32'd3);
      if (wa.size() == 3) begin
         chk("t3_a0", 32'(wa[0]), 32'h3FF);
         chk("t3_a1", 32'(wa[1]), 32'h000);
         chk("t3_a2", 32'(wa[2]), 32'h001);
         chk("t3_d2", 32'(wd[2]), 32'h0003);
      end
      chk("t3_ndone", 32'(dc.size()), 32'd1);

      // Word_Count=0 loads all 1024 entries
      clear_log();
      start_load(10'h100, 11'd0, 1'b0);
      for (int i = 0; i < 1023; i++) send_word(16'h0000);
      send_word(16'hFFFF);
      wait_done(10);
      chk("t4_csum", 32'(Checksum), 32'hFFFF);
      Byte_Valid = 1'b0;
      step();
      chk("t4_nwr", 32'(wa.size()), 32'd1024);
      if (wa.size() == 1024) begin
         chk("t4_first_a", 32'(wa[0]),    32'h100);
         chk("t4_last_a",  32'(wa[1023]), 32'h0FF);
         chk("t4_last_d",  32'(wd[1023]), 32'hFFFF);
      end
      chk("t4_ndone", 32'(dc.size()), 32'd1);

      // Reset after the high byte of word 2 of 4
      clear_log();
      start_load(10'h020, 11'd4, 1'b0);
      send_word(16'h1111);
      send_byte(8'h22);
      Byte_Valid = 1'b0;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("t5_busy",  32'(Busy),       32'd0);
      chk("t5_ready", 32'(Byte_Ready), 32'd0);
      chk("t5_we",    32'(TriRAM_WE),  32'd0);
      chk("t5_csum",  32'(Checksum),   32'd0);
      for (int i = 0; i < 4; i++) step();
      chk("t5_nwr",   32'(wa.size()), 32'd1);
      chk("t5_ndone", 32'(dc.size()), 32'd0);
      start_load(10'h010, 11'd1, 1'b0);
      send_word(16'hBEEF);
      wait_done(10);
      chk("t5_csum2", 32'(Checksum), 32'hBEEF);
      Byte_Valid = 1'b0;
      step();
      chk("t5_nwr2", 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         chk("t5_a", 32'(wa[1]), 32'h010);
         chk("t5_d", 32'(wd[1]), 32'hBEEF);
      end

`ifdef TRI_AUTOGEN_EN
      // Triangle generator
      clear_log();
      Byte_in = 8'h77; Byte_Valid = 1'b1;
      start_load(10'h155, 11'd5, 1'b1);
      chk("t6_ready", 32'(Byte_Ready), 32'd0);
      wait_done(1100);
      chk("t6_csum", 32'(Checksum), 32'h0000);
      Byte_Valid = 1'b0;
      step();
      chk("t6_nwr", 32'(wa.size()), 32'd1024);
      if (wa.size() == 1024) begin
         chk("t6_a0",    32'(wa[0]),    32'h000);
         chk("t6_d0",    32'(wd[0]),    32'h0000);
         chk("t6_d511",  32'(wd[511]),  32'hFF80);
         chk("t6_d512",  32'(wd[512]),  32'hFF80);
         chk("t6_a1023", 32'(wa[1023]), 32'h3FF);
         chk("t6_d1023", 32'(wd[1023]), 32'h0000);
         chk("t6_span",  32'(wc[1023] - wc[0]), 32'd1023);
      end
      chk("t6_ndone", 32'(dc.size()), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/triangle_ram_loader.md
# triangle_ram_loader

Writer side of the DDFS triangle/arbitrary waveform RAM. It accepts a host byte stream over a valid/ready handshake and assembles big-endian 16-bit samples. It drives the 1K×16 RAM write port (address, data, write-enable) from a programmable start address, with address wrap-around. It sits between the host interface logic and the waveform RAM write port of the DDFS, running in the RAM's write-clock domain.

## Interface
Parameters:
- ADDR_W, 10, RAM address width (1024 entries)
- DATA_W, 16, sample width; always two bytes

Ports:
- Clock  in  1  write-side clock; all logic rising-edge
- Reset  in  1  synchronous, active-high
- Start  in  1  load-start pulse; sampled only in IDLE
- Start_Addr  in  10  first RAM address of the load
- Word_Count  in  11  words to load, 1..1024; 0 is treated as 1024
- Autogen  in  1  with Start: self-generate triangle table (effective only with TRI_AUTOGEN_EN)
- Byte_in  in  8  host data byte
- Byte_Valid  in  1  Byte_in valid
- Byte_Ready  out  1  loader can accept a byte
- Triangle_Addr  out  10  RAM write address
- Triangle_Data  out  16  RAM write data
- TriRAM_WE  out  1  RAM write strobe, one cycle per word
- Busy  out  1  load in progress
- Done  out  1  one-cycle pulse after final write
- Checksum  out  16  sum mod 2^16 of words written in current/last load

## Operation
- States: IDLE, HI, LO, WRITE, DONE, and GEN (GEN only with TRI_AUTOGEN_EN).
- IDLE:
  - Start=1, Autogen=0 → latch Start_Addr into the address counter, latch Word_Count into the remaining counter (0→1024), clear Checksum → HI.
  - Start=1, Autogen=1, macro present → GEN.
- HI: Byte_Ready=1. On Byte_Valid&&Byte_Ready, store the byte as data[15:8] → LO.
- LO: Byte_Ready=1. On handshake, store the byte as data[7:0] → WRITE.
- WRITE: TriRAM_WE=1 with current address/data; Checksum += data.
  - Address increments mod 1024 (1023→0); remaining decrements.
  - Remaining was 1 → DONE, else → HI.
- DONE: Done=1 for one cycle → IDLE.
- Byte_Ready=0 in IDLE, WRITE, DONE and GEN. Bytes presented then are not consumed and must be held by the source.
- Start outside IDLE is ignored. There is no abort other than Reset.
- Busy=1 in every state except IDLE.
- Triangle_Addr/Triangle_Data hold their last values when TriRAM_WE=0.

## Timing
- Reset values: Byte_Ready=0, TriRAM_WE=0, Busy=0, Done=0, Triangle_Addr=0, Triangle_Data=0, Checksum=0, state IDLE.
- Start accepted at edge n → Busy=1 and Byte_Ready=1 from cycle n+1.
- Low byte accepted at edge m → TriRAM_WE=1 during cycle m+1 (one cycle), address/data valid the same cycle.
- Minimum 3 cycles per word with Byte_Valid held high.
- Done=1 the cycle after the final WRITE; Busy falls with Done's deassertion, back in IDLE.
- Checksum is final and stable from the Done cycle until the next accepted Start.
- Reset mid-load takes effect at the next edge: WE=0, Byte_Ready=0, counters cleared, partial byte discarded, no Done.

## Configuration
- TRI_AUTOGEN_EN defined: GEN state compiled in.
  - Start with Autogen=1 writes all 1024 entries, one per cycle, and ignores Start_Addr, Word_Count and the byte stream.
  - Address a runs 0..1023; data = {a[9] ? ~a[8:0] : a[8:0], 7'b0} (symmetric triangle, peak 0xFF80 at a=511 and 512).
  - Checksum accumulates as normal; then DONE.
- Undefined: Autogen is ignored and Start always starts a byte load. GEN logic is absent.

## Test plan
- Reset then idle: all outputs 0, Byte_Ready=0; bytes offered are not consumed.
- Start, Start_Addr=0x005, Word_Count=2, bytes 12 34 AB CD with Valid constant → writes 0x1234@5 and 0xABCD@6 three cycles apart; Done one cycle after the second WE; Checksum=0xBE01.
- Start_Addr=0x3FF, Word_Count=3, words 0001 0002 0003 → addresses 0x3FF, 0x000, 0x001 (wrap); Checksum=0x0006.
- Word_Count=0, bytes all 0x00 except the final word 0xFFFF → exactly 1024 WE pulses, final write at Start_Addr−1 mod 1024, Checksum=0xFFFF.
- Reset asserted after the high byte of word 2 of 4 → next cycle IDLE, WE never asserted for word 2, no Done; a new Start then loads normally.
- TRI_AUTOGEN_EN, Start with Autogen=1 → 1024 consecutive WE cycles; data 0x0000@0, 0xFF80@511, 0xFF80@512, 0x0000@1023; Checksum=0x0000; Done once.
